sideband_queue: RTL and testbench
=================================

# sideband_queue

Parametrised multi-channel sideband descriptor queue for the packet filter. It holds one metadata word per frame (length, destination mask, drop/keep verdict) for each of `NUM_CH` ingress ports. Ingress logic writes descriptors; the switch FSM reads them in order alongside the frame data FIFOs. All channels share one memory, each channel is an independent circular buffer, and any channel can be flushed on its own.

## Interface
- `ADDR_WIDTH`, 9: log2 of per-channel depth; `DEPTH = 2**ADDR_WIDTH` entries per channel.
- `W_EL`, 20: descriptor width in bits.
- `NUM_CH`, 4: number of channels, ≥1; `CH_W = max(1, $clog2(NUM_CH))`.
- `CNT_W`, 8: width of each per-channel overflow counter.
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `wen`  in  1  write request.
- `wch`  in  CH_W  write channel.
- `wdata`  in  W_EL  descriptor to write.
- `full`  out  NUM_CH  bit c set when channel c holds DEPTH entries.
- `ren`  in  1  read request.
- `rch`  in  CH_W  read channel.
- `rdata`  out  W_EL  registered read data.
- `rvalid`  out  1  `rdata` updated this cycle from an accepted read.
- `empty`  out  NUM_CH  bit c set when channel c holds 0 entries.
- `flush`  in  1  flush request.
- `fch`  in  CH_W  channel to flush.
- `count`  out  NUM_CH*(ADDR_WIDTH+1)  per-channel occupancy, channel c at bits [c*(ADDR_WIDTH+1) +: ADDR_WIDTH+1].
- `ovf_cnt`  out  NUM_CH*CNT_W  per-channel overflow counters, same packing.

## Operation
- Storage: one RAM of `NUM_CH*DEPTH` words addressed `{ch, ptr}`. Each channel has its own `rptr`/`wptr` (ADDR_WIDTH bits, wrap modulo DEPTH) and `count` (ADDR_WIDTH+1 bits).
- `full[c] = (count_c == DEPTH)`, `empty[c] = (count_c == 0)`. Both come from registered counts, so they are combinational-free.
- Write accepted iff `wen && !full[wch] && !(flush && fch==wch)`. An accepted write stores at `{wch, wptr}` and increments `wptr`. A refused write is discarded without side effects, except for the overflow count described under Configuration.
- Read accepted iff `ren && !empty[rch] && !(flush && fch==rch)`. An accepted read latches `mem[{rch, rptr}]` into `rdata`, sets `rvalid`=1 next cycle and increments `rptr`. A refused read leaves `rdata` held and `rvalid`=0.
- Flush: sets `rptr`=`wptr`=0 and `count`=0 on channel `fch` only. It overrides any write or read to the same channel in that cycle. Other channels proceed normally. Memory contents are not cleared.
- Count update per channel: +1 on write only, −1 on read only, unchanged when both happen on that channel, 0 on flush.
- Fullness is judged at the start of the cycle. A write to a full channel is refused even if a read of that channel is accepted in the same cycle.
- No new state machine is needed: the per-channel pointer/count registers are the state.

## Timing
- Reset values: `rdata`=0, `rvalid`=0, all pointers and counts 0, `empty`=all ones, `full`=0, `count`=0, `ovf_cnt`=0.
- Write-to-read latency: a descriptor written in cycle N is readable in N+1, because `empty` deasserts in N+1. Read data appears in `rdata` one cycle after the accepted `ren`.
- `full`, `empty` and `count` reflect all accepted operations one cycle after the edge at which they occur.
- Reset asserted mid-operation returns everything to reset values immediately. An in-flight read is lost and `rvalid` drops asynchronously.

## Configuration
- `SIDEBAND_OVF_STATS_EN`
  - Defined: `ovf_cnt[c]` increments whenever `wen && wch==c && full[c]` and no same-channel flush is active. It saturates at `2**CNT_W−1`. Flushing channel c clears `ovf_cnt[c]`.
  - Undefined: no counter registers are built and `ovf_cnt` is tied to 0.

## Test plan
- Reset, then write 0x00001..0x00003 to ch2 and read ch2 three times. Required: `rdata`=1,2,3 each with `rvalid`=1, then `empty[2]`=1 and `count` ch2=0. Other channels stay untouched.
- Fill ch0 with 512 writes: `full[0]`=1 after the 512th. The 513th write is refused, and `ovf_cnt` ch0=1 with the macro (0 without). Then read 512 entries in order: the pointer wraps correctly and the 513th value is never seen.
- Simultaneous write ch1 and read ch1 with count=5: count stays 5 and data order is preserved. Same on full ch1: read accepted, write refused, count=511.
- Write 4 entries to ch3, then flush ch3 together with wen/ren on ch3 and a write to ch0. Required: ch3 count=0 and `empty[3]`=1; the ch0 write is accepted.
- Assert reset mid-stream with ch1 holding 7 entries and a read pending. Required: `rvalid`=0, `count`=0 and all `empty` set immediately. Operation resumes correctly after release.
- With the macro defined and `CNT_W`=2, issue 5 writes to a full channel: `ovf_cnt` saturates at 3.

Source files
------------

// File: rtl/sideband_queue.sv
// sideband_queue: NUM_CH independent circular descriptor queues sharing one RAM.
// Overflow statistics are built only when SIDEBAND_OVF_STATS_EN is defined.
module sideband_queue #(
    parameter int ADDR_WIDTH = 9,
    parameter int W_EL       = 20,
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 8,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             wen,
    input  logic [CH_W-1:0]                  wch,
    input  logic [W_EL-1:0]                  wdata,
    output logic [NUM_CH-1:0]                full,
    input  logic                             ren,
    input  logic [CH_W-1:0]                  rch,
    output logic [W_EL-1:0]                  rdata,
    output logic                             rvalid,
    output logic [NUM_CH-1:0]                empty,
    input  logic                             flush,
    input  logic [CH_W-1:0]                  fch,
    output logic [NUM_CH*(ADDR_WIDTH+1)-1:0] count,
    output logic [NUM_CH*CNT_W-1:0]          ovf_cnt
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int AW    = CH_W + ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

    logic [W_EL-1:0]       mem [NUM_CH*DEPTH];

    logic [ADDR_WIDTH-1:0] wptr_q  [NUM_CH];
    logic [ADDR_WIDTH-1:0] wptr_d  [NUM_CH];
    logic [ADDR_WIDTH-1:0] rptr_q  [NUM_CH];
    logic [ADDR_WIDTH-1:0] rptr_d  [NUM_CH];
    logic [ADDR_WIDTH:0]   count_q [NUM_CH];
    logic [ADDR_WIDTH:0]   count_d [NUM_CH];
    logic [W_EL-1:0]       rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;

    logic [NUM_CH-1:0]     full_c, empty_c, fl_c, wsel_c, wr_c, rd_c;
    logic                  wr_go, rd_go;
    logic [AW-1:0]         wr_addr, rd_addr;

    always_comb begin
        wr_go   = 1'b0;
        rd_go   = 1'b0;
        wr_addr = '0;
        rd_addr = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            full_c[c]  = (count_q[c] == DEPTH_C);
            empty_c[c] = (count_q[c] == '0);
            fl_c[c]    = flush && (fch == CH_W'(c));
            wsel_c[c]  = wen && (wch == CH_W'(c));
            // Fullness/emptiness judged on start-of-cycle counts; flush wins on its channel.
            wr_c[c]    = wsel_c[c] && !full_c[c] && !fl_c[c];
            rd_c[c]    = ren && (rch == CH_W'(c)) && !empty_c[c] && !fl_c[c];
            if (wr_c[c]) begin
                wr_go   = 1'b1;
                wr_addr = {CH_W'(c), wptr_q[c]};
            end
            if (rd_c[c]) begin
                rd_go   = 1'b1;
                rd_addr = {CH_W'(c), rptr_q[c]};
            end
            wptr_d[c]  = wptr_q[c];
            rptr_d[c]  = rptr_q[c];
            count_d[c] = count_q[c];
            if (fl_c[c]) begin
                wptr_d[c]  = '0;
                rptr_d[c]  = '0;
                count_d[c] = '0;
            end else begin
                if (wr_c[c]) wptr_d[c] = wptr_q[c] + ADDR_WIDTH'(1);
                if (rd_c[c]) rptr_d[c] = rptr_q[c] + ADDR_WIDTH'(1);
                if (wr_c[c] && !rd_c[c]) count_d[c] = count_q[c] + (ADDR_WIDTH+1)'(1);
                if (rd_c[c] && !wr_c[c]) count_d[c] = count_q[c] - (ADDR_WIDTH+1)'(1);
            end
        end
        rdata_d  = rd_go ? mem[rd_addr] : rdata_q;
        rvalid_d = rd_go;
    end

    always_ff @(posedge clk) begin
        if (wr_go) mem[wr_addr] <= wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wptr_q[c]  <= '0;
                rptr_q[c]  <= '0;
                count_q[c] <= '0;
            end
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                wptr_q[c]  <= wptr_d[c];
                rptr_q[c]  <= rptr_d[c];
                count_q[c] <= count_d[c];
            end
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign full   = full_c;
    assign empty  = empty_c;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_count
        assign count[g*(ADDR_WIDTH+1) +: ADDR_WIDTH+1] = count_q[g];
    end

`ifdef SIDEBAND_OVF_STATS_EN
    logic [CNT_W-1:0] ovf_q [NUM_CH];
    logic [CNT_W-1:0] ovf_d [NUM_CH];

    // Refused writes to a full channel are counted, saturating; flush clears.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            ovf_d[c] = ovf_q[c];
            if (fl_c[c])
                ovf_d[c] = '0;
            else if (wsel_c[c] && full_c[c] && (ovf_q[c] != '1))
                ovf_d[c] = ovf_q[c] + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) ovf_q[c] <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) ovf_q[c] <= ovf_d[c];
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ovf
        assign ovf_cnt[g*CNT_W +: CNT_W] = ovf_q[g];
    end
`else
    assign ovf_cnt = '0;
`endif

endmodule

// File: tb/tb_sideband_queue.sv
// Directed bench for sideband_queue: default instance plus a small instance
// used to reach full/saturation conditions quickly.
module tb_sideband_queue;
    localparam int OVF_ON =
`ifdef SIDEBAND_OVF_STATS_EN
        1;
`else
        0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        wen, ren, flush;
    logic [1:0]  wch, rch, fch;
    logic [19:0] wdata;
    logic [3:0]  full, empty;
    logic [19:0] rdata;
    logic        rvalid;
    logic [39:0] count;
    logic [31:0] ovf_cnt;

    logic        s_wen, s_ren, s_flush;
    logic        s_wch, s_rch, s_fch;
    logic [7:0]  s_wdata, s_rdata;
    logic [1:0]  s_full, s_empty;
    logic        s_rvalid;
    logic [5:0]  s_count;
    logic [3:0]  s_ovf;

    int n_cmp = 0;
    int n_err = 0;

    sideband_queue u_dut (
        .clk(clk), .reset(reset), .wen(wen), .wch(wch), .wdata(wdata), .full(full),
        .ren(ren), .rch(rch), .rdata(rdata), .rvalid(rvalid), .empty(empty),
        .flush(flush), .fch(fch), .count(count), .ovf_cnt(ovf_cnt)
    );

    sideband_queue #(.ADDR_WIDTH(2), .W_EL(8), .NUM_CH(2), .CNT_W(2)) u_small (
        .clk(clk), .reset(reset), .wen(s_wen), .wch(s_wch), .wdata(s_wdata), .full(s_full),
        .ren(s_ren), .rch(s_rch), .rdata(s_rdata), .rvalid(s_rvalid), .empty(s_empty),
        .flush(s_flush), .fch(s_fch), .count(s_count), .ovf_cnt(s_ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] cnt(input int ch);
        return count[ch*10 +: 10];
    endfunction

    function automatic logic [7:0] ovf(input int ch);
        return ovf_cnt[ch*8 +: 8];
    endfunction

    task automatic idle();
        wen = 1'b0; ren = 1'b0; flush = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        wen = 0; ren = 0; flush = 0; wch = 0; rch = 0; fch = 0; wdata = 0;
        s_wen = 0; s_ren = 0; s_flush = 0; s_wch = 0; s_rch = 0; s_fch = 0; s_wdata = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_rdata", 64'(rdata), 64'h0);
        check("rst_rvalid", 64'(rvalid), 64'h0);
        check("rst_empty", 64'(empty), 64'hF);
        check("rst_full", 64'(full), 64'h0);
        check("rst_count", 64'(count), 64'h0);
        check("rst_ovf", 64'(ovf_cnt), 64'h0);

        // ch2 basic write/read
        for (int i = 1; i <= 3; i++) begin
            wen = 1; wch = 2; wdata = 20'(i);
            tick();
        end
        wen = 0;
        check("ch2_count3", 64'(cnt(2)), 64'd3);
        check("ch2_empty", 64'(empty), 64'b1011);
        for (int i = 1; i <= 3; i++) begin
            ren = 1; rch = 2;
            tick();
            check("ch2_read", 64'({rvalid, rdata}), 64'({1'b1, 20'(i)}));
        end
        ren = 0;
        tick();
        check("ch2_rvalid_off", 64'(rvalid), 64'h0);
        check("ch2_drained_empty", 64'(empty), 64'hF);
        check("ch2_drained_count", 64'(count), 64'h0);

        // ch0 fill, overflow, drain with wrap
        wen = 1; wch = 0;
        for (int i = 0; i < 512; i++) begin
            wdata = 20'h10000 + 20'(i);
            tick();
        end
        check("ch0_full", 64'(full), 64'b0001);
        check("ch0_count512", 64'(cnt(0)), 64'd512);
        wdata = 20'hDEAD0;
        tick();
        wen = 0;
        check("ch0_ovf_count", 64'(cnt(0)), 64'd512);
        check("ch0_ovf_cnt", 64'(ovf(0)), 64'(OVF_ON));
        ren = 1; rch = 0;
        for (int i = 0; i < 512; i++) begin
            tick();
            check("ch0_drain", 64'({rvalid, rdata}), 64'({1'b1, 20'h10000 + 20'(i)}));
        end
        ren = 0;
        tick();
        check("ch0_refused_read_rvalid", 64'(rvalid), 64'h0);
        check("ch0_rdata_held", 64'(rdata), 64'h101FF);
        check("ch0_empty_after", 64'(empty), 64'hF);
        check("ch0_full_after", 64'(full), 64'h0);

        // ch1 simultaneous read/write at count 5
        wen = 1; wch = 1;
        for (int i = 0; i < 5; i++) begin
            wdata = 20'hA0 + 20'(i);
            tick();
        end
        check("ch1_count5", 64'(cnt(1)), 64'd5);
        ren = 1; rch = 1; wdata = 20'hA5;
        tick();
        check("ch1_rw_data0", 64'(rdata), 64'hA0);
        check("ch1_rw_count0", 64'(cnt(1)), 64'd5);
        wdata = 20'hA6;
        tick();
        check("ch1_rw_data1", 64'(rdata), 64'hA1);
        check("ch1_rw_count1", 64'(cnt(1)), 64'd5);
        wen = 0;
        for (int i = 2; i <= 6; i++) begin
            tick();
            check("ch1_order", 64'({rvalid, rdata}), 64'({1'b1, 20'hA0 + 20'(i)}));
        end
        ren = 0;
        tick();
        check("ch1_count0", 64'(cnt(1)), 64'd0);

        // ch1 full with simultaneous read/write
        wen = 1; wch = 1;
        for (int i = 0; i < 512; i++) begin
            wdata = 20'h20000 + 20'(i);
            tick();
        end
        check("ch1_full", 64'(full), 64'b0010);
        wdata = 20'hBEEF0; ren = 1; rch = 1;
        tick();
        idle();
        check("ch1_full_rw_data", 64'({rvalid, rdata}), 64'({1'b1, 20'h20000}));
        check("ch1_full_rw_count", 64'(cnt(1)), 64'd511);
        check("ch1_full_rw_fullflag", 64'(full), 64'h0);
        check("ch1_ovf", 64'(ovf(1)), 64'(OVF_ON));
        flush = 1; fch = 1;
        tick();
        flush = 0;
        check("ch1_flush_count", 64'(cnt(1)), 64'd0);
        check("ch1_flush_ovf", 64'(ovf(1)), 64'd0);
        check("ch0_ovf_kept", 64'(ovf(0)), 64'(OVF_ON));
        check("ch1_flush_empty", 64'(empty), 64'hF);

        // ch3 flush overriding same-channel traffic, other channel proceeds
        wen = 1; wch = 3;
        for (int i = 0; i < 4; i++) begin
            wdata = 20'h30 + 20'(i);
            tick();
        end
        wen = 0;
        check("ch3_count4", 64'(cnt(3)), 64'd4);
        flush = 1; fch = 3; ren = 1; rch = 3; wen = 1; wch = 0; wdata = 20'h77;
        tick();
        idle();
        check("ch3_flush_count", 64'(cnt(3)), 64'd0);
        check("ch3_flush_empty", 64'(empty[3]), 64'd1);
        check("ch3_flush_rvalid", 64'(rvalid), 64'd0);
        check("ch0_write_during_flush", 64'(cnt(0)), 64'd1);
        wen = 1; wch = 3;
        for (int i = 0; i < 4; i++) begin
            wdata = 20'h40 + 20'(i);
            tick();
        end
        flush = 1; fch = 3; ren = 1; rch = 3; wen = 1; wch = 3; wdata = 20'h99;
        tick();
        idle();
        check("ch3_flush_rw_count", 64'(cnt(3)), 64'd0);
        check("ch3_flush_rw_rvalid", 64'(rvalid), 64'd0);
        ren = 1; rch = 0;
        tick();
        check("ch0_read_77", 64'({rvalid, rdata}), 64'({1'b1, 20'h77}));
        ren = 0; wen = 1; wch = 3; wdata = 20'h55;
        tick();
        wen = 0; ren = 1; rch = 3;
        tick();
        ren = 0;
        check("ch3_ptr_reset_read", 64'({rvalid, rdata}), 64'({1'b1, 20'h55}));
        tick();
        check("ch3_rdata_held", 64'({rvalid, rdata}), 64'({1'b0, 20'h55}));

        // asynchronous reset mid-stream
        wen = 1; wch = 1;
        for (int i = 0; i < 7; i++) begin
            wdata = 20'h300 + 20'(i);
            tick();
        end
        wen = 0; ren = 1; rch = 1;
        tick();
        check("pre_rst_read", 64'({rvalid, rdata}), 64'({1'b1, 20'h300}));
        check("pre_rst_count", 64'(cnt(1)), 64'd6);
        #1 reset = 1'b1;
        #1;
        check("async_rst_rvalid", 64'(rvalid), 64'd0);
        check("async_rst_count", 64'(count), 64'd0);
        check("async_rst_empty", 64'(empty), 64'hF);
        check("async_rst_rdata", 64'(rdata), 64'd0);
        check("async_rst_ovf", 64'(ovf_cnt), 64'd0);
        #1 reset = 1'b0;
        ren = 0;
        tick();
        check("post_rst_empty", 64'(empty), 64'hF);
        wen = 1; wch = 1; wdata = 20'hABC;
        tick();
        wen = 0; ren = 1; rch = 1;
        tick();
        ren = 0;
        check("post_rst_read", 64'({rvalid, rdata}), 64'({1'b1, 20'hABC}));
        check("post_rst_count", 64'(cnt(1)), 64'd0);

        // small instance: overflow counter saturation
        s_wen = 1; s_wch = 1;
        for (int i = 0; i < 4; i++) begin
            s_wdata = 8'(i + 1);
            tick();
        end
        check("small_full", 64'(s_full), 64'b10);
        s_wdata = 8'hEE;
        repeat (5) tick();
        s_wen = 0;
        check("small_count", 64'(s_count[5:3]), 64'd4);
        check("small_ovf_sat", 64'(s_ovf[3:2]), 64'(OVF_ON ? 3 : 0));
        check("small_ovf_other", 64'(s_ovf[1:0]), 64'd0);
        s_ren = 1; s_rch = 1;
        tick();
        s_ren = 0;
        check("small_read_first", 64'({s_rvalid, s_rdata}), 64'({1'b1, 8'h01}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
